font_loader: RTL



---
 rtl/font_loader.sv | 139 +++++++++++++
 1 files changed

// File: rtl/font_loader.sv
// Byte-stream glyph loader for the VGA console font RAM: an index byte followed
// by 16 row bytes writes one glyph; a clear request zero-fills the whole memory.
module font_loader #(
    parameter  int GLYPH_BITS = 8,
    parameter  int ROW_BITS   = 4,
    localparam int ADDR_W     = GLYPH_BITS + ROW_BITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              clear,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [0:7]        mem_wdata,
    output logic              glyph_done,
    output logic              busy
);

    localparam logic [1:0] S_GLYPH = 2'd0;
    localparam logic [1:0] S_ROWS  = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;

    logic [1:0]            r_state;
    logic [GLYPH_BITS-1:0] r_glyph;
    logic [ROW_BITS-1:0]   r_row;
    logic [ADDR_W-1:0]     r_clr_cnt;
    logic                  r_mem_we;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [0:7]            r_mem_wdata;
    logic                  r_glyph_done;
    logic                  r_busy;

    logic [1:0]            w_state_nx;
    logic [GLYPH_BITS-1:0] w_glyph_nx;
    logic [ROW_BITS-1:0]   w_row_nx;
    logic [ADDR_W-1:0]     w_clr_cnt_nx;
    logic                  w_mem_we_nx;
    logic [ADDR_W-1:0]     w_mem_addr_nx;
    logic [0:7]            w_mem_wdata_nx;
    logic                  w_glyph_done_nx;
    logic                  w_busy_nx;
    logic                  w_hs;

    assign in_ready = (r_state != S_CLEAR) && !clear;
    assign w_hs     = in_valid && in_ready;

    // Next-state and next-output decode; clear outranks any pending byte.
    always_comb begin
        w_state_nx      = r_state;
        w_glyph_nx      = r_glyph;
        w_row_nx        = r_row;
        w_clr_cnt_nx    = r_clr_cnt;
        w_mem_we_nx     = 1'b0;
        w_mem_addr_nx   = r_mem_addr;
        w_mem_wdata_nx  = r_mem_wdata;
        w_glyph_done_nx = 1'b0;
        w_busy_nx       = r_busy;
        case (r_state)
            S_GLYPH, S_ROWS: begin
                if (clear) begin
                    // Address 0 is written on entry, so the counter starts at 1.
                    w_state_nx     = S_CLEAR;
                    w_mem_we_nx    = 1'b1;
                    w_mem_addr_nx  = {ADDR_W{1'b0}};
                    w_mem_wdata_nx = 8'h00;
                    w_clr_cnt_nx   = {{(ADDR_W-1){1'b0}}, 1'b1};
                    w_busy_nx      = 1'b1;
                end else if (w_hs && (r_state == S_GLYPH)) begin
                    w_glyph_nx = in_data[GLYPH_BITS-1:0];
                    w_row_nx   = {ROW_BITS{1'b0}};
                    w_state_nx = S_ROWS;
                end else if (w_hs) begin
                    w_mem_we_nx    = 1'b1;
                    w_mem_addr_nx  = {r_glyph, r_row};
                    w_mem_wdata_nx = in_data;
                    w_row_nx       = r_row + {{(ROW_BITS-1){1'b0}}, 1'b1};
                    if (r_row == {ROW_BITS{1'b1}}) begin
                        w_glyph_done_nx = 1'b1;
                        w_state_nx      = S_GLYPH;
                    end else begin
                        w_state_nx = S_ROWS;
                    end
                end else begin
                    w_state_nx = r_state;
                end
            end
            S_CLEAR: begin
                // The counter wraps to zero only after the all-ones address is written.
                if (r_clr_cnt == {ADDR_W{1'b0}}) begin
                    w_state_nx = S_GLYPH;
                    w_busy_nx  = 1'b0;
                end else begin
                    w_mem_we_nx    = 1'b1;
                    w_mem_addr_nx  = r_clr_cnt;
                    w_mem_wdata_nx = 8'h00;
                    w_clr_cnt_nx   = r_clr_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                w_state_nx = S_GLYPH;
                w_busy_nx  = 1'b0;
            end
        endcase
    end

    // State and registered RAM-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_GLYPH;
            r_glyph      <= {GLYPH_BITS{1'b0}};
            r_row        <= {ROW_BITS{1'b0}};
            r_clr_cnt    <= {ADDR_W{1'b0}};
            r_mem_we     <= 1'b0;
            r_mem_addr   <= {ADDR_W{1'b0}};
            r_mem_wdata  <= 8'h00;
            r_glyph_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_glyph      <= w_glyph_nx;
            r_row        <= w_row_nx;
            r_clr_cnt    <= w_clr_cnt_nx;
            r_mem_we     <= w_mem_we_nx;
            r_mem_addr   <= w_mem_addr_nx;
            r_mem_wdata  <= w_mem_wdata_nx;
            r_glyph_done <= w_glyph_done_nx;
            r_busy       <= w_busy_nx;
        end
    end

    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign glyph_done = r_glyph_done;
    assign busy       = r_busy;

endmodule
